softmax_strided_loader: RTL and testbench
=========================================

SOFTMAX_STRIDED_LOADER -- requirements
Module: softmax_strided_loader

Interface
REQ-001 SHALL have parameter XAW, default 32, meaning external byte-address and length width.
REQ-002 SHALL have parameter XDW, default 128, meaning read-master beat width (multiple of DW).
REQ-003 SHALL have parameter DW, default 32, meaning output word width; WCNT = XDW/DW words per beat.
REQ-004 SHALL have parameter MAXB, default 32, meaning maximum beats per burst (power of 2).
REQ-005 SHALL have parameter FD, default 64, meaning output FIFO depth in words (power of 2, >= 2*WCNT).
REQ-006 SHALL have parameter LW, default 16, meaning row-length width in words; CW, default 12, meaning row-count width.
REQ-007 SHALL have ports (clock and reset first):
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous active-high reset
- cfg_go  in  1  start pulse
- cfg_base  in  XAW  byte address of row 0
- cfg_len  in  LW  words per row
- cfg_rows  in  CW  row count
- cfg_stride  in  XAW  byte distance between row starts
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- rmst_fixed_location  out  1  constant 0
- rmst_read_base  out  XAW  burst byte address
- rmst_read_length  out  XAW  burst length in bytes
- rmst_go  out  1  one-cycle burst start
- rmst_done  in  1  burst complete pulse
- rmst_user_read_buffer  out  1  pop one beat
- rmst_user_buffer_data  in  XDW  beat data
- rmst_user_data_available  in  1  beat present
- out_valid  out  1  word available
- out_data  out  DW  word
- out_last  out  1  last word of current row
- out_ready  in  1  consumer accepts word

Function
REQ-008 SHALL latch cfg_* on cfg_go in IDLE; cfg_go in any other state SHALL be ignored.
REQ-009 SHALL implement FSM IDLE -> SETUP -> ISSUE -> WAIT -> (ISSUE | ROWEND) ; ROWEND -> (SETUP | FINISH) ; FINISH -> IDLE.
REQ-010 SETUP: row_beats = ceil(len/WCNT), row address = base + row_index*stride (accumulated, modulo 2^XAW).
REQ-011 ISSUE: burst = min(remaining row beats, MAXB); rmst_go pulses one cycle; rmst_read_base/length held stable from that cycle until rmst_done; length = burst*XDW/8.
REQ-012 WAIT: on rmst_done, subtract burst; remaining > 0 -> ISSUE at next address (base + burst*XDW/8); remaining = 0 -> wait until all row words are pushed to FIFO, then ROWEND.
REQ-013 Latency: cfg_go at cycle 0 -> rmst_go at cycle 2.
REQ-014 Unpacker: rmst_user_read_buffer SHALL assert for one cycle only when rmst_user_data_available=1, unpack register empty or emitting its final word, and FIFO free space >= WCNT; beat captured that edge.
REQ-015 Unpacker SHALL push words LSB-first, one per cycle; words beyond cfg_len in the row's last beat SHALL be discarded, not pushed.
REQ-016 FIFO entry = {last, data}; last=1 on word index len-1 of each row.
REQ-017 out_valid = FIFO not empty (show-ahead); pop when out_valid & out_ready; write and pop same cycle on full/empty boundary SHALL both succeed without loss or duplication.
REQ-018 FIFO SHALL never overflow; out_valid SHALL never assert on invalid data.
REQ-019 FINISH: done pulses one cycle after last word written into FIFO (not after consumption); busy=1 from cycle after cfg_go until done cycle inclusive.
REQ-020 cfg_len=0 or cfg_rows=0: no rmst_go, no words; done pulses at cycle 2 after cfg_go.
REQ-021 Row-to-row gap SHALL be <= 3 cycles excluding read-master latency.

Reset
REQ-022 rst SHALL be synchronous active-high; asserted at any time (including mid-burst) SHALL return FSM to IDLE, empty FIFO and unpacker, and drive busy, done, rmst_go, rmst_user_read_buffer, out_valid, out_last = 0, rmst_read_base/length = 0, out_data = 0.
REQ-023 After rst mid-operation, stray rmst_done/data_available SHALL be ignored until the next cfg_go starts a burst.

Verification
REQ-024 base=0x1000, len=8, rows=1, out_ready=1 -> one rmst_go, base 0x1000, length 32; 8 words in order, out_last on word 8; done once.
REQ-025 len=70, rows=1, MAXB=8, WCNT=4 -> 18 beats as bursts 8,8,2 at 0x..+0/+128/+256; 70 words pushed, 2 padding words dropped.
REQ-026 rows=3, len=5, stride=0x400 -> bases base, base+0x400, base+0x800; 15 words; out_last on words 5,10,15.
REQ-027 out_ready=0 for 200 cycles with len=256 -> FIFO holds 64 words, rmst_user_read_buffer stays 0, no overflow; on release all 256 words arrive in order.
REQ-028 rst asserted 3 cycles after second rmst_go -> next cycle all outputs 0, FSM IDLE; fresh cfg_go completes correctly.
REQ-029 cfg_len=0 -> done at cycle 2, zero rmst_go; cfg_go while busy -> no effect on transfer.

Source files
------------

// File: rtl/softmax_strided_loader.sv
`default_nettype none
// ============================================================================
// Module   : softmax_strided_loader
// Brief    : Fetches strided rows through a burst read master and unpacks the
//            beats into a show-ahead word FIFO, marking each row's last word.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_strided_loader #(
  parameter int XAW  = 32,
  parameter int XDW  = 128,
  parameter int DW   = 32,
  parameter int MAXB = 32,
  parameter int FD   = 64,
  parameter int LW   = 16,
  parameter int CW   = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_go,
  input  logic [XAW-1:0] cfg_base,
  input  logic [LW-1:0]  cfg_len,
  input  logic [CW-1:0]  cfg_rows,
  input  logic [XAW-1:0] cfg_stride,
  output logic           busy,
  output logic           done,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [XAW-1:0] rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           rmst_user_read_buffer,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  input  logic           rmst_user_data_available,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  output logic           out_last,
  input  logic           out_ready
);

  localparam int c_WCNT = XDW / DW;
  localparam int c_WSH  = (c_WCNT > 1) ? $clog2(c_WCNT) : 0;
  localparam int c_IW   = (c_WCNT > 1) ? $clog2(c_WCNT) : 1;
  localparam int c_AW   = $clog2(FD);
  localparam int c_CNTW = c_AW + 1;
  localparam logic [XAW-1:0] c_BEAT_BYTES = XAW'(XDW / 8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_ROWEND = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t          r_state, w_state_next;
  logic [LW-1:0]   r_len, r_row_beats, r_rem, r_burst;
  logic [CW-1:0]   r_rows_left;
  logic [XAW-1:0]  r_stride, r_row_addr, r_rd_base, r_rd_len;
  logic            r_row_done;

  logic [XDW-1:0]  r_beat;
  logic            r_uvalid;
  logic [c_IW-1:0] r_idx;
  logic [LW-1:0]   r_word_cnt;

  logic [DW:0]     r_mem [FD];
  logic [c_AW-1:0] r_wr, r_rd;
  logic [c_CNTW-1:0] r_count;

  logic [LW-1:0]   w_row_beats_cfg, w_setup_burst, w_rem_next, w_next_burst;
  logic            w_accept, w_push, w_pop, w_read, w_word_last, w_final, w_push_last;
  logic [c_CNTW-1:0] w_free;

  assign w_row_beats_cfg = LW'(({1'b0, cfg_len} + (LW+1)'(c_WCNT - 1)) >> c_WSH);
  assign w_setup_burst   = (r_row_beats > LW'(MAXB)) ? LW'(MAXB) : r_row_beats;
  assign w_rem_next      = r_rem - r_burst;
  assign w_next_burst    = (w_rem_next > LW'(MAXB)) ? LW'(MAXB) : w_rem_next;

  // Beats are only taken while a burst of the current transfer is outstanding.
  assign w_accept    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_push      = r_uvalid;
  assign w_word_last = (r_word_cnt == r_len - LW'(1));
  assign w_final     = w_word_last || (r_idx == c_IW'(c_WCNT - 1));
  assign w_push_last = w_push && w_word_last;
  assign w_free      = c_CNTW'(FD) - r_count;
  assign w_read      = rmst_user_data_available && w_accept && (!r_uvalid || w_final) &&
                       (w_free >= c_CNTW'(c_WCNT) + c_CNTW'(r_uvalid));
  assign w_pop       = (r_count != '0) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (cfg_go) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = (r_len == '0 || r_rows_left == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:  w_state_next = S_WAIT;
      S_WAIT: begin
        if (rmst_done && r_rem != '0) begin
          if (w_rem_next != '0) w_state_next = S_ISSUE;
        end else if (r_rem == '0 && (r_row_done || w_push_last)) begin
          w_state_next = S_ROWEND;
        end
      end
      S_ROWEND: w_state_next = (r_rows_left > CW'(1)) ? S_SETUP : S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_row_beats <= '0;
      r_rows_left <= '0;
      r_stride    <= '0;
      r_row_addr  <= '0;
      r_rem       <= '0;
      r_burst     <= '0;
      r_rd_base   <= '0;
      r_rd_len    <= '0;
      r_row_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (cfg_go) begin
          r_len       <= cfg_len;
          r_row_beats <= w_row_beats_cfg;
          r_rows_left <= cfg_rows;
          r_stride    <= cfg_stride;
          r_row_addr  <= cfg_base;
        end
        S_SETUP: begin
          r_rem      <= r_row_beats;
          r_burst    <= w_setup_burst;
          r_rd_base  <= r_row_addr;
          r_rd_len   <= XAW'(w_setup_burst) * c_BEAT_BYTES;
          r_row_done <= 1'b0;
        end
        S_WAIT: begin
          // Burst address/length only move once the previous burst has completed.
          if (rmst_done && r_rem != '0) begin
            r_rem <= w_rem_next;
            if (w_rem_next != '0) begin
              r_burst   <= w_next_burst;
              r_rd_base <= r_rd_base + XAW'(r_burst) * c_BEAT_BYTES;
              r_rd_len  <= XAW'(w_next_burst) * c_BEAT_BYTES;
            end
          end
          if (w_push_last) r_row_done <= 1'b1;
        end
        S_ROWEND: begin
          r_rows_left <= r_rows_left - CW'(1);
          r_row_addr  <= r_row_addr + r_stride;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat     <= '0;
      r_uvalid   <= 1'b0;
      r_idx      <= '0;
      r_word_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && cfg_go) r_word_cnt <= '0;
      else if (w_push)                 r_word_cnt <= w_word_last ? '0 : r_word_cnt + LW'(1);
      // Words past the row length are dropped by ending the beat early.
      if (w_read) begin
        r_beat   <= rmst_user_buffer_data;
        r_uvalid <= 1'b1;
        r_idx    <= '0;
      end else if (w_push) begin
        r_beat <= r_beat >> DW;
        r_idx  <= r_idx + c_IW'(1);
        if (w_final) r_uvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_word_last, r_beat[DW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop)  r_rd <= r_rd + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNTW'(1);
        2'b01:   r_count <= r_count - c_CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid             = (r_count != '0);
  assign out_data              = out_valid ? r_mem[r_rd][DW-1:0] : '0;
  assign out_last              = out_valid ? r_mem[r_rd][DW] : 1'b0;
  assign busy                  = (r_state != S_IDLE);
  assign done                  = (r_state == S_FINISH);
  assign rmst_go               = (r_state == S_ISSUE);
  assign rmst_fixed_location   = 1'b0;
  assign rmst_read_base        = r_rd_base;
  assign rmst_read_length      = r_rd_len;
  assign rmst_user_read_buffer = w_read;

endmodule
`default_nettype wire

// File: tb/tb_softmax_strided_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_strided_loader
// Brief    : Scoreboard bench with a behavioural read master for the loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_strided_loader;
  localparam int XAW = 32, XDW = 128, DW = 32, MAXB = 8, FD = 64, LW = 16, CW = 12;

  logic           clk, rst, cfg_go;
  logic [XAW-1:0] cfg_base, cfg_stride;
  logic [LW-1:0]  cfg_len;
  logic [CW-1:0]  cfg_rows;
  logic           busy, done, rmst_fixed_location, rmst_go, rmst_done;
  logic [XAW-1:0] rmst_read_base, rmst_read_length;
  logic           rmst_user_read_buffer, rmst_user_data_available;
  logic [XDW-1:0] rmst_user_buffer_data;
  logic           out_valid, out_last, out_ready;
  logic [DW-1:0]  out_data;

  softmax_strided_loader #(.XAW(XAW), .XDW(XDW), .DW(DW), .MAXB(MAXB), .FD(FD), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_rows(cfg_rows), .cfg_stride(cfg_stride), .busy(busy), .done(done),
    .rmst_fixed_location(rmst_fixed_location), .rmst_read_base(rmst_read_base),
    .rmst_read_length(rmst_read_length), .rmst_go(rmst_go), .rmst_done(rmst_done),
    .rmst_user_read_buffer(rmst_user_read_buffer), .rmst_user_buffer_data(rmst_user_buffer_data),
    .rmst_user_data_available(rmst_user_data_available), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready));

  int n_total = 0, n_bad = 0;
  int go_cnt = 0, done_cnt = 0, rd_stall = 0;
  bit rand_mode = 0, ready_level = 1, stall_mon = 0;
  logic [32:0] exp_words[$];
  logic [63:0] exp_bursts[$];
  logic [31:0] beat_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [XDW-1:0] mk_beat(input logic [31:0] a);
    logic [XDW-1:0] v;
    for (int i = 0; i < XDW / DW; i++) v[i*DW +: DW] = a + 32'(4 * i);
    return v;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Behavioural read master: one burst in flight, beats addressed by byte address.
  initial begin
    logic go_s, rd_s, rst_s;
    logic [31:0] b_s, l_s;
    logic [63:0] e;
    int cur_left;
    cur_left = 0;
    rmst_done = 0; rmst_user_data_available = 0; rmst_user_buffer_data = '0;
    forever begin
      @(negedge clk);
      go_s = rmst_go; rd_s = rmst_user_read_buffer; rst_s = rst;
      b_s = rmst_read_base; l_s = rmst_read_length;
      if (go_s) go_cnt++;
      if (done) done_cnt++;
      if (stall_mon && rmst_user_read_buffer) rd_stall++;
      @(posedge clk); #1;
      rmst_done = 0;
      if (rst_s) begin
        beat_q.delete();
        cur_left = 0;
      end else begin
        if (rd_s && beat_q.size() > 0) begin
          void'(beat_q.pop_front());
          cur_left--;
          if (cur_left == 0) rmst_done = 1;
        end
        if (go_s) begin
          chk("burst_overlap", cur_left, 0);
          e = (exp_bursts.size() > 0) ? exp_bursts.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
          chk("burst_base_len", {b_s, l_s}, e);
          for (int k = 0; k < int'(l_s / 16); k++) beat_q.push_back(b_s + 32'(16 * k));
          cur_left = int'(l_s / 16);
        end
      end
      rmst_user_data_available = (beat_q.size() > 0);
      rmst_user_buffer_data = (beat_q.size() > 0) ? mk_beat(beat_q[0]) : '0;
    end
  end

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        e = (exp_words.size() > 0) ? exp_words.pop_front() : 33'h1_DEAD_BEEF;
        chk("word", {out_last, out_data}, e);
      end
    end
  end

  task automatic push_expect(input logic [31:0] base, input int len, input int rows,
                             input logic [31:0] stride);
    logic [31:0] a, ba;
    int rem, b;
    a = base;
    for (int r = 0; r < rows; r++) begin
      rem = (len + 3) / 4;
      ba = a;
      while (rem > 0) begin
        b = (rem > MAXB) ? MAXB : rem;
        exp_bursts.push_back({ba, 32'(b * 16)});
        ba += 32'(b * 16);
        rem -= b;
      end
      for (int j = 0; j < len; j++) exp_words.push_back({(j == len - 1), a + 32'(4 * j)});
      a += stride;
    end
  endtask

  task automatic start_cfg(input logic [31:0] base, input int len, input int rows,
                           input logic [31:0] stride);
    @(posedge clk); #1;
    cfg_base = base; cfg_len = LW'(len); cfg_rows = CW'(rows); cfg_stride = stride;
    cfg_go = 1;
    @(posedge clk); #1;
    cfg_go = 0;
  endtask

  task automatic check_latency(input bit zero);
    int cyc;
    chk("busy_cycle1", busy, 1);
    cyc = 1;
    @(negedge clk);
    while (!(zero ? done : rmst_go) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk(zero ? "done_latency" : "go_latency", cyc, 2);
  endtask

  task automatic finish_xfer(input int d0, input int g0, input bit zero);
    int c;
    c = 0;
    while (done_cnt == d0 && c < 20000) begin @(negedge clk); c++; end
    c = 0;
    while (exp_words.size() != 0 && c < 20000) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    chk("words_left", exp_words.size(), 0);
    chk("bursts_left", exp_bursts.size(), 0);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_idle", busy, 0);
    if (zero) chk("no_go", go_cnt - g0, 0);
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input int rows,
                          input logic [31:0] stride);
    int d0, g0;
    bit zero;
    zero = (len == 0) || (rows == 0);
    d0 = done_cnt; g0 = go_cnt;
    push_expect(base, len, rows, stride);
    start_cfg(base, len, rows, stride);
    check_latency(zero);
    finish_xfer(d0, g0, zero);
  endtask

  initial begin
    int d0, g0, n, c;
    rst = 1; cfg_go = 0; cfg_base = '0; cfg_len = '0; cfg_rows = '0; cfg_stride = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_go", rmst_go, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_base_len", {rmst_read_base, rmst_read_length}, 0);
    chk("rst_fixed", rmst_fixed_location, 0);
    rst = 0;

    run_xfer(32'h1000, 8, 1, 0);
    run_xfer(32'h10000, 70, 1, 0);
    run_xfer(32'h5000, 0, 3, 32'h100);
    run_xfer(32'h5000, 4, 0, 32'h100);

    // Strided rows under random backpressure, with a cfg_go pulse while busy.
    rand_mode = 1;
    d0 = done_cnt; g0 = go_cnt;
    push_expect(32'h4000, 5, 3, 32'h400);
    start_cfg(32'h4000, 5, 3, 32'h400);
    check_latency(0);
    repeat (3) @(posedge clk);
    #1;
    cfg_base = 32'h9990_0000; cfg_len = 16'd100; cfg_rows = 12'd7; cfg_go = 1;
    @(posedge clk); #1;
    cfg_go = 0;
    finish_xfer(d0, g0, 0);

    for (int t = 0; t < 3; t++)
      run_xfer(32'h40000 + 32'(t) * 32'h10000, int'($urandom_range(1, 40)),
               int'($urandom_range(1, 4)), 32'($urandom_range(1, 16)) * 32'h40);
    rand_mode = 0;

    // Long stall: FIFO fills and the read strobe must stay low.
    ready_level = 0;
    repeat (2) @(posedge clk);
    d0 = done_cnt; g0 = go_cnt;
    push_expect(32'h8000, 256, 1, 0);
    start_cfg(32'h8000, 256, 1, 0);
    repeat (100) @(posedge clk);
    stall_mon = 1;
    rd_stall = 0;
    repeat (100) @(posedge clk);
    stall_mon = 0;
    @(negedge clk);
    chk("stall_rd", rd_stall, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_none_popped", exp_words.size(), 256);
    chk("stall_no_done", done_cnt - d0, 0);
    ready_level = 1;
    finish_xfer(d0, g0, 0);

    // Reset three cycles after the second burst start.
    push_expect(32'h20000, 64, 2, 32'h1000);
    start_cfg(32'h20000, 64, 2, 32'h1000);
    n = 0; c = 0;
    while (n < 2 && c < 500) begin
      @(negedge clk);
      c++;
      if (rmst_go) n++;
    end
    chk("two_bursts", n, 2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_words.delete();
    exp_bursts.delete();
    chk("mid_rst_busy_done", {busy, done}, 0);
    chk("mid_rst_go_rd", {rmst_go, rmst_user_read_buffer}, 0);
    chk("mid_rst_out", {out_valid, out_last, out_data}, 0);
    chk("mid_rst_base_len", {rmst_read_base, rmst_read_length}, 0);
    repeat (5) @(posedge clk);
    chk("mid_rst_idle", busy, 0);
    run_xfer(32'h3000, 12, 2, 32'h100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
